// File: rtl/simple_dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
// Contents are not reset.
module simple_dp_ram #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     wr_clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DWIDTH-1:0]        rd_data
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge wr_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fwft_sync_fifo.sv
// First-word-fall-through synchronous FIFO: DEPTH-entry RAM followed by a
// registered output stage, giving DEPTH+1 words of total capacity.
module fwft_sync_fifo #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DWIDTH-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [DWIDTH-1:0]        m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DWIDTH-1:0] rd_data;
    logic              ram_empty;
    logic              ram_full;
    logic              wr_en;
    logic              load;
    logic              pop;

    // MSB of each pointer is a wrap flag distinguishing full from empty
    assign ram_empty = (wr_ptr == rd_ptr);
    assign ram_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign s_ready   = !ram_full;
    assign wr_en     = s_valid && !ram_full;
    assign load      = (!m_valid || m_ready) && !ram_empty;
    assign pop       = m_valid && m_ready;

    simple_dp_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_ram (
        .wr_clk  (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (s_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            count   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (load) begin
                m_data  <= rd_data;
                m_valid <= 1'b1;
                rd_ptr  <= rd_ptr + PW'(1);
            end else if (pop) begin
                m_valid <= 1'b0;
            end
            if (wr_en && !pop) begin
                count <= count + PW'(1);
            end else if (!wr_en && pop) begin
                count <= count - PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwft_sync_fifo.sv
// Randomised and directed bench for fwft_sync_fifo against a queue-based model
// of the held words plus a flag for whether the head is currently presented.
module tb_fwft_sync_fifo;

    localparam int DW = 64;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [4:0]    count;

    int tests = 0;
    int fails = 0;

    fwft_sync_fifo #(
        .DWIDTH (DW),
        .DEPTH  (DP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: q holds every word in the FIFO in order; mv says q[0] is presented.
    logic [DW-1:0] q[$];
    bit            mv;
    logic [DW-1:0] last_data;
    int            ram_n;
    bit            push_m, pop_m, load_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            mv        = 0;
            last_data = '0;
        end else begin
            ram_n  = q.size() - (mv ? 1 : 0);
            push_m = s_valid && (ram_n < DP);
            pop_m  = mv && m_ready;
            load_m = (!mv || m_ready) && (ram_n > 0);
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back(s_data);
            if (load_m) mv = 1;
            else if (pop_m) mv = 0;
            if (mv) last_data = q[0];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m_valid", {63'd0, m_valid}, {63'd0, mv});
            check("m_data", m_data, last_data);
            check("count", {59'd0, count}, DW'(q.size()));
            check("s_ready", {63'd0, s_ready}, {63'd0, (q.size() - (mv ? 1 : 0)) < DP});
        end
    end

    logic [DW-1:0] got[$];
    int            maxc;

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        // reset state
        cyc();
        #1 rst = 1'b0;
        cyc();
        check("rst_count", {59'd0, count}, 64'd0);
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_s_ready", {63'd0, s_ready}, 64'd1);
        check("rst_m_data", m_data, 64'd0);

        // single write: no same-cycle bypass, visible one edge later
        s_valid = 1; s_data = 64'hA5;
        cyc();
        s_valid = 0;
        check("a5_no_bypass", {63'd0, m_valid}, 64'd0);
        check("a5_count1", {59'd0, count}, 64'd1);
        cyc();
        check("a5_m_valid", {63'd0, m_valid}, 64'd1);
        check("a5_m_data", m_data, 64'hA5);
        check("a5_count2", {59'd0, count}, 64'd1);
        m_ready = 1;
        cyc();
        m_ready = 0;
        check("a5_drained", {59'd0, count}, 64'd0);

        // fill to DEPTH+1, then one dropped write
        for (int i = 0; i <= DP; i++) begin
            s_valid = 1; s_data = DW'(i);
            cyc();
        end
        check("full_s_ready", {63'd0, s_ready}, 64'd0);
        check("full_count", {59'd0, count}, 64'd17);
        s_data = 64'h99;
        cyc();
        s_valid = 0;
        check("drop_count", {59'd0, count}, 64'd17);

        // drain in order
        m_ready = 1;
        for (int i = 0; i <= DP; i++) begin
            check("drain_valid", {63'd0, m_valid}, 64'd1);
            check("drain_data", m_data, DW'(i));
            if (i == 1) check("drain_s_ready", {63'd0, s_ready}, 64'd1);
            cyc();
        end
        check("drain_count", {59'd0, count}, 64'd0);
        check("drain_m_valid", {63'd0, m_valid}, 64'd0);

        // streaming through two pointer wraps
        maxc = 0;
        for (int c = 0; c < 48; c++) begin
            if (m_valid && m_ready) got.push_back(m_data);
            if (int'(count) > maxc) maxc = int'(count);
            s_valid = (c < 40);
            s_data  = DW'(100 + c);
            cyc();
        end
        check("stream_n", DW'(got.size()), 64'd40);
        for (int i = 0; i < 40 && i < got.size(); i++) check("stream_data", got[i], DW'(100 + i));
        check("stream_maxc", DW'(maxc), 64'd2);

        // head held under backpressure while writes continue
        m_ready = 0; s_valid = 1; s_data = 64'd200;
        cyc();
        s_valid = 0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {63'd0, m_valid}, 64'd1);
            check("hold_data", m_data, 64'd200);
            s_valid = 1; s_data = DW'(201 + i);
            cyc();
        end
        s_valid = 0;
        check("hold_count", {59'd0, count}, 64'd6);
        m_ready = 1;
        repeat (10) cyc();

        // random traffic with varying bias
        for (int c = 0; c < 3000; c++) begin
            if (c < 1000) begin
                s_valid = ($urandom_range(0, 9) < 8); m_ready = ($urandom_range(0, 9) < 3);
            end else if (c < 2000) begin
                s_valid = ($urandom_range(0, 9) < 3); m_ready = ($urandom_range(0, 9) < 8);
            end else begin
                s_valid = $urandom_range(0, 1); m_ready = $urandom_range(0, 1);
            end
            s_data = {$urandom, $urandom};
            cyc();
        end

        // reset mid-operation with 9 words held
        s_valid = 0; m_ready = 1;
        repeat (20) cyc();
        m_ready = 0;
        for (int i = 0; i < 9; i++) begin
            s_valid = 1; s_data = DW'(300 + i);
            cyc();
        end
        s_valid = 0;
        check("pre_rst_count", {59'd0, count}, 64'd9);
        #2 rst = 1'b1;
        cyc();
        #1 rst = 1'b0;
        cyc();
        check("post_rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("post_rst_count", {59'd0, count}, 64'd0);
        check("post_rst_s_ready", {63'd0, s_ready}, 64'd1);
        s_valid = 1; s_data = 64'h3C;
        cyc();
        s_valid = 0;
        cyc();
        check("post_rst_valid", {63'd0, m_valid}, 64'd1);
        check("post_rst_data", m_data, 64'h3C);
        m_ready = 1;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fwft_sync_fifo.md
FWFT_SYNC_FIFO -- requirements
Module: fwft_sync_fifo

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, storage-RAM entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_data  input  DWIDTH  write payload.
REQ-006 SHALL have port s_valid  input  1  write request.
REQ-007 SHALL have port s_ready  output  1  space available in RAM.
REQ-008 SHALL have port m_data  output  DWIDTH  head-of-queue payload, registered.
REQ-009 SHALL have port m_valid  output  1  m_data holds a valid word.
REQ-010 SHALL have port m_ready  input  1  consumer accepts head word.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  words held: RAM plus output register, 0..DEPTH+1.

Function
REQ-012 SHALL accept a write on a posedge where s_valid && s_ready, storing s_data at wr_ptr and incrementing wr_ptr.
REQ-013 SHALL hold wr_ptr and rd_ptr at $clog2(DEPTH)+1 bits; the MSB is a wrap flag, and the low bits address the RAM modulo DEPTH.
REQ-014 SHALL define ram_empty as wr_ptr == rd_ptr, and ram_full as equal low bits with differing MSB.
REQ-015 SHALL drive s_ready = !ram_full, with no combinational path from m_ready or s_valid.
REQ-016 SHALL load the output register when (!m_valid || m_ready) && !ram_empty: m_data <= RAM word at rd_ptr, m_valid <= 1, rd_ptr increments.
REQ-017 SHALL clear m_valid when m_valid && m_ready && ram_empty.
REQ-018 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-019 SHALL present a word written at posedge k into an empty FIFO on m_data with m_valid=1 after posedge k+1; there is no same-cycle bypass.
REQ-020 SHALL permit a write and an output-register load on the same posedge; each pointer updates independently.
REQ-021 SHALL provide a total capacity of DEPTH+1 words.
REQ-022 SHALL update count registered each posedge: +1 on write only, -1 on m_valid && m_ready only, unchanged on both or neither.
REQ-023 SHALL ignore s_valid while s_ready=0, and leave m_data unchanged when m_ready is asserted with m_valid=0.
REQ-024 SHALL preserve strict FIFO order across pointer wrap-around, with no loss or duplication.

Reset
REQ-025 SHALL asynchronously force wr_ptr=0, rd_ptr=0, m_valid=0, m_data=0 and count=0 while rst=1.
REQ-026 SHALL not reset RAM contents; stale entries are unreachable because the pointers are equal.
REQ-027 SHALL discard all held words when rst asserts mid-operation; s_ready=1 on the first posedge after rst deasserts.

Structure
REQ-028 SHALL place no typedefs in a shared package; pointer width is a localparam derived from DEPTH.
REQ-029 SHALL instantiate simple_dp_ram (DWIDTH, DEPTH) as its sole sub-module, with wr_clk=clk, async read at rd_ptr low bits.
REQ-030 SHALL implement the remaining logic, namely pointers, output register and count, in this module.

Verification (DWIDTH=64, DEPTH=16)
REQ-031 SHALL cover: after reset, write 0xA5 at posedge 1 -> m_valid=1, m_data=0xA5, count=1 after posedge 2.
REQ-032 SHALL cover: m_ready=0, write 0..16 -> all 17 accepted, s_ready=0, count=17; a further s_valid is dropped.
REQ-033 SHALL cover: full FIFO with m_ready=1 for 17 cycles -> reads 0..16 in order, s_ready=1 after the first pop, count=0, m_valid=0.
REQ-034 SHALL cover: continuous write and read of 40 incrementing words -> 40 outputs in order across two wraps, count bounded at 2.
REQ-035 SHALL cover: m_valid=1 with m_ready=0 for 5 cycles -> m_data stable, with writes continuing behind it.
REQ-036 SHALL cover: rst pulse with count=9 -> m_valid=0, count=0, s_ready=1; the next write, 0x3C, is the next output.
